// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// State encoding, target-select codes and fixed addresses.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [1:0] SEL_IMM  = 2'b00;
    localparam logic [1:0] SEL_REGA = 2'b01;
    localparam logic [1:0] SEL_JUMP = 2'b10;
    localparam logic [1:0] SEL_VEC  = 2'b11;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] VEC_ADDR = 32'h0000_0040;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pc_select.sv
// Redirect target mux for the fetch stage.
// Every target leaves here word aligned.
module pc_select import fetch_stage_pkg::*; (
    input  logic [1:0]  selpctype,
    input  logic [31:0] rega,
    input  logic [31:0] pcimd2ext,
    input  logic [31:0] pcindex,
    input  logic [31:0] nextpc,
    output logic [31:0] target
);

    logic [31:0] raw;
    logic        unused_bits;

    assign unused_bits = ^{pcindex[31:26], nextpc[27:0]};

    always_comb begin
        raw = pcimd2ext;
        unique case (selpctype)
            SEL_IMM:  raw = pcimd2ext;
            SEL_REGA: raw = rega;
            SEL_JUMP: raw = {nextpc[31:28], pcindex[25:0], 2'b00};
            SEL_VEC:  raw = VEC_ADDR;
            default:  raw = pcimd2ext;
        endcase
        target = align_word(raw);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory request,
// one-entry skid buffer and redirect handling into IF/ID.
module fetch_stage import fetch_stage_pkg::*; (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_if_selpcsource,
    input  logic [1:0]  id_if_selpctype,
    input  logic [31:0] id_if_rega,
    input  logic [31:0] id_if_pcimd2ext,
    input  logic [31:0] id_if_pcindex,
    input  logic        ex_if_stall,
    output logic        if_mem_req,
    output logic [31:0] if_mem_addr,
    input  logic        mem_if_ready,
    input  logic [31:0] mem_if_data,
    output logic [31:0] if_id_instruc,
    output logic [31:0] if_id_nextpc,
    output logic        if_id_valid
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n, pc4, target;
    logic [31:0]  drain_addr, drain_addr_n;
    logic [31:0]  skid_instr, skid_instr_n;
    logic [31:0]  skid_nextpc, skid_nextpc_n;
    logic [31:0]  instruc_n, nextpc_n;
    logic         valid_n, redirect;

    assign pc4      = pc + 32'd4;
    assign redirect = id_if_selpcsource & if_id_valid & ~ex_if_stall;

    pc_select u_pc_select (
        .selpctype (id_if_selpctype),
        .rega      (id_if_rega),
        .pcimd2ext (id_if_pcimd2ext),
        .pcindex   (id_if_pcindex),
        .nextpc    (if_id_nextpc),
        .target    (target)
    );

    // DRAIN keeps presenting the abandoned address so the request stays stable
    assign if_mem_req  = reset & (state != ST_HOLD);
    assign if_mem_addr = !reset ? 32'h0 :
                         (state == ST_DRAIN) ? drain_addr : pc;

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        drain_addr_n  = drain_addr;
        skid_instr_n  = skid_instr;
        skid_nextpc_n = skid_nextpc;
        instruc_n     = if_id_instruc;
        nextpc_n      = if_id_nextpc;
        valid_n       = if_id_valid;

        unique case (state)
            ST_FETCH: state_n = ST_WAIT;
            ST_WAIT: begin
                if (mem_if_ready) begin
                    if (ex_if_stall) begin
                        skid_instr_n  = mem_if_data;
                        skid_nextpc_n = pc4;
                        state_n       = ST_HOLD;
                    end else begin
                        instruc_n = mem_if_data;
                        nextpc_n  = pc4;
                        valid_n   = 1'b1;
                        pc_n      = pc4;
                        state_n   = ST_FETCH;
                    end
                end
            end
            ST_HOLD: begin
                if (!ex_if_stall) begin
                    instruc_n = skid_instr;
                    nextpc_n  = skid_nextpc;
                    valid_n   = 1'b1;
                    pc_n      = pc4;
                    state_n   = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (mem_if_ready) state_n = ST_FETCH;
            end
            default: state_n = ST_FETCH;
        endcase

        // Redirect overrides any load, including a word returning this cycle
        if (redirect) begin
            pc_n      = target;
            instruc_n = NOP_WORD;
            nextpc_n  = if_id_nextpc;
            valid_n   = 1'b0;
            if (state == ST_WAIT && !mem_if_ready) begin
                state_n      = ST_DRAIN;
                drain_addr_n = pc;
            end else begin
                state_n = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_FETCH;
            pc            <= RESET_PC;
            drain_addr    <= 32'h0;
            skid_instr    <= 32'h0;
            skid_nextpc   <= 32'h0;
            if_id_instruc <= NOP_WORD;
            if_id_nextpc  <= 32'h0;
            if_id_valid   <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            drain_addr    <= drain_addr_n;
            skid_instr    <= skid_instr_n;
            skid_nextpc   <= skid_nextpc_n;
            if_id_instruc <= instruc_n;
            if_id_nextpc  <= nextpc_n;
            if_id_valid   <= valid_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic
// compared each cycle against a transaction-level model.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_if_selpcsource;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_rega;
    logic [31:0] id_if_pcimd2ext;
    logic [31:0] id_if_pcindex;
    logic        ex_if_stall;
    logic        if_mem_req;
    logic [31:0] if_mem_addr;
    logic        mem_if_ready;
    logic [31:0] mem_if_data;
    logic [31:0] if_id_instruc;
    logic [31:0] if_id_nextpc;
    logic        if_id_valid;

    int total = 0;
    int bad   = 0;

    // model: pc, whether a request is live, whether it was already presented,
    // whether its data must be dropped, and a skid queue of depth one
    logic [31:0] m_pc, m_daddr, m_ii, m_in;
    logic [31:0] m_sk_i, m_sk_n;
    bit          m_out, m_wait, m_drop, m_skid, m_iv;

    fetch_stage dut (
        .clock             (clock),
        .reset             (reset),
        .id_if_selpcsource (id_if_selpcsource),
        .id_if_selpctype   (id_if_selpctype),
        .id_if_rega        (id_if_rega),
        .id_if_pcimd2ext   (id_if_pcimd2ext),
        .id_if_pcindex     (id_if_pcindex),
        .ex_if_stall       (ex_if_stall),
        .if_mem_req        (if_mem_req),
        .if_mem_addr       (if_mem_addr),
        .mem_if_ready      (mem_if_ready),
        .mem_if_data       (mem_if_data),
        .if_id_instruc     (if_id_instruc),
        .if_id_nextpc      (if_id_nextpc),
        .if_id_valid       (if_id_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_3C3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input bit r);
        if (!r) return 32'h0;
        return m_drop ? m_daddr : m_pc;
    endfunction

    task automatic model_step();
        logic [31:0] tgt;
        bit redir, got;
        if (!reset) begin
            m_pc = 0; m_daddr = 0; m_ii = 0; m_in = 0;
            m_sk_i = 0; m_sk_n = 0; m_iv = 0;
            m_out = 1; m_wait = 0; m_drop = 0; m_skid = 0;
        end else begin
            redir = id_if_selpcsource && m_iv && !ex_if_stall;
            got   = m_out && m_wait && mem_if_ready;
            case (id_if_selpctype)
                2'd0:    tgt = id_if_pcimd2ext;
                2'd1:    tgt = id_if_rega;
                2'd2:    tgt = {m_in[31:28], id_if_pcindex[25:0], 2'b00};
                default: tgt = 32'h40;
            endcase
            tgt[1:0] = 2'b00;
            if (redir) begin
                if (m_out && m_wait && !got) begin
                    m_drop = 1; m_daddr = m_pc;
                end else begin
                    m_out = 1; m_wait = 0; m_drop = 0;
                end
                m_pc = tgt; m_iv = 0; m_ii = 0; m_skid = 0;
            end else if (m_skid) begin
                if (!ex_if_stall) begin
                    m_ii = m_sk_i; m_in = m_sk_n; m_iv = 1;
                    m_pc = m_pc + 4; m_skid = 0;
                    m_out = 1; m_wait = 0;
                end
            end else if (m_out && !m_wait) begin
                m_wait = 1;
            end else if (got) begin
                m_wait = 0;
                if (m_drop) begin
                    m_drop = 0;
                end else if (ex_if_stall) begin
                    m_skid = 1; m_out = 0;
                    m_sk_i = mem_if_data; m_sk_n = m_pc + 4;
                end else begin
                    m_ii = mem_if_data; m_in = m_pc + 4; m_iv = 1;
                    m_pc = m_pc + 4;
                end
            end
        end
    endtask

    task automatic drive(input bit r, input bit st, input bit rdy,
                         input bit sel, input logic [1:0] t,
                         input logic [31:0] ra, input logic [31:0] im,
                         input logic [31:0] ix);
        bit e_req;
        reset             = r;
        ex_if_stall       = st;
        mem_if_ready      = rdy;
        id_if_selpcsource = sel;
        id_if_selpctype   = t;
        id_if_rega        = ra;
        id_if_pcimd2ext   = im;
        id_if_pcindex     = ix;
        mem_if_data       = rdy ? mem_word(exp_addr(r)) : 32'hDEAD_BEEF;
        #1;
        e_req = r && m_out;
        check("req", 32'(if_mem_req), 32'(e_req));
        if (e_req || !r) check("addr", if_mem_addr, exp_addr(r));
        check("valid", 32'(if_id_valid), 32'(m_iv));
        check("instr", if_id_instruc, m_ii);
        check("nextpc", if_id_nextpc, m_in);
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic tick(input bit r, input bit st, input bit rdy);
        drive(r, st, rdy, 0, 2'd0, 0, 0, 0);
        step();
    endtask

    initial begin
        reset = 0; ex_if_stall = 0; mem_if_ready = 0; mem_if_data = 0;
        id_if_selpcsource = 0; id_if_selpctype = 0;
        id_if_rega = 0; id_if_pcimd2ext = 0; id_if_pcindex = 0;
        repeat (2) @(posedge clock);
        model_step();
        @(negedge clock);

        // reset state
        drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
        check("rst_req", 32'(if_mem_req), 32'h0);
        step();
        check("rst_valid", 32'(if_id_valid), 32'h0);

        // straight-line fetch, ready every second cycle
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
            check("sl_addr", if_mem_addr, 32'(4 * k));
            step();
            tick(1, 0, 1);
            check("sl_np", if_id_nextpc, 32'(4 * (k + 1)));
            check("sl_valid", 32'(if_id_valid), 32'h1);
        end

        // stall while the word at 8 returns
        tick(0, 0, 0);
        tick(1, 0, 0); tick(1, 0, 1);
        tick(1, 0, 0); tick(1, 0, 1);
        drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
        check("st_addr", if_mem_addr, 32'h8);
        step();
        drive(1, 1, 1, 0, 2'd0, 0, 0, 0);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0, 2'd0, 0, 0, 0);
            check("st_hold_np", if_id_nextpc, 32'h8);
            check("st_hold_in", if_id_instruc, mem_word(32'h4));
            check("st_hold_req", 32'(if_mem_req), 32'h0);
            step();
        end
        tick(1, 0, 0);
        drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
        check("st_next", if_mem_addr, 32'hC);
        check("st_in", if_id_instruc, mem_word(32'h8));
        step();

        // branch redirect while waiting on 12
        drive(1, 0, 0, 1, 2'd0, 0, 32'h100, 0);
        step();
        drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
        check("br_valid", 32'(if_id_valid), 32'h0);
        check("br_drain_req", 32'(if_mem_req), 32'h1);
        step();
        drive(1, 0, 1, 0, 2'd0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
        check("br_addr", if_mem_addr, 32'h100);
        check("br_valid2", 32'(if_id_valid), 32'h0);
        step();
        tick(1, 0, 1);

        // jump: first land on 0x4000_000C so nextpc becomes 0x4000_0010
        drive(1, 0, 0, 1, 2'd1, 32'h4000_000C, 0, 0);
        step();
        drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
        check("jp_pre", if_mem_addr, 32'h4000_000C);
        step();
        tick(1, 0, 1);
        check("jp_np", if_id_nextpc, 32'h4000_0010);
        drive(1, 0, 0, 1, 2'd2, 0, 0, 32'h40);
        step();
        drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
        check("jp_addr", if_mem_addr, 32'h4000_0100);
        step();
        tick(1, 0, 1);

        // jr to the top word and wrap to 0
        drive(1, 0, 0, 1, 2'd1, 32'hFFFF_FFFC, 0, 0);
        step();
        drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
        check("jr_addr", if_mem_addr, 32'hFFFF_FFFC);
        step();
        tick(1, 0, 1);
        check("jr_np", if_id_nextpc, 32'h0);
        drive(1, 0, 0, 0, 2'd0, 0, 0, 0);
        check("jr_wrap", if_mem_addr, 32'h0);
        step();

        // reset with the request outstanding, then a late ready
        drive(0, 0, 0, 0, 2'd0, 0, 0, 0);
        check("rw_req", 32'(if_mem_req), 32'h0);
        step();
        check("rw_valid", 32'(if_id_valid), 32'h0);
        check("rw_np", if_id_nextpc, 32'h0);
        drive(1, 0, 1, 0, 2'd0, 0, 0, 0);
        check("rw_first", if_mem_addr, 32'h0);
        check("rw_first_req", 32'(if_mem_req), 32'h1);
        step();
        check("rw_late", 32'(if_id_valid), 32'h0);
        tick(1, 0, 1);
        check("rw_in", if_id_instruc, mem_word(32'h0));

        // random traffic
        for (int n = 0; n < 800; n++) begin
            bit r, st, rdy, sel;
            logic [1:0] t;
            r   = ($urandom_range(99) != 0);
            st  = ($urandom_range(3) == 0);
            rdy = 1'($urandom_range(1));
            sel = ($urandom_range(3) == 0);
            t   = 2'($urandom_range(3));
            drive(r, st, rdy, sel, t, $urandom, $urandom, $urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
